rv_fwd_bypass: RTL

Parametrised operand-bypass and load-use interlock unit for the RV32 core. It sits between the register-file read ports and the ALU operand inputs. It selects, per source operand, the youngest in-flight value for that register from four places: the ALU2 stage, the write stage, an N-deep write-back history, or the register file. It raises a stall when the youngest producer's result is not yet available, and counts stall cycles for performance monitoring.

---
 rtl/rv_fwd_bypass_pkg.sv | 26 ++
 rtl/rv_fwd_mux.sv | 72 +++++++
 rtl/rv_fwd_bypass.sv | 115 +++++++++++
 3 files changed

// File: rtl/rv_fwd_bypass_pkg.sv
// Shared types for the operand bypass unit: forwarding-source encoding and
// counter limits, also consumed by the debug trace.
package rv_fwd_bypass_pkg;

    localparam int FWD_SRC_W    = 3;
    localparam int MAX_WB_DEPTH = 4;
    localparam int STALL_CNT_W  = 32;

    localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = '1;

    typedef enum logic [FWD_SRC_W-1:0] {
        SRC_REGFILE = 3'd0,
        SRC_ALU2    = 3'd1,
        SRC_WRITE   = 3'd2,
        SRC_HIST0   = 3'd3,
        SRC_HIST1   = 3'd4,
        SRC_HIST2   = 3'd5,
        SRC_HIST3   = 3'd6
    } fwd_src_t;

    // History slot k reports as HIST_k, which sits at SRC_HIST0 + k.
    function automatic fwd_src_t hist_src(input int slot);
        return fwd_src_t'(FWD_SRC_W'(int'(SRC_HIST0) + slot));
    endfunction

endpackage

// File: rtl/rv_fwd_mux.sv
// Single-operand bypass select: picks the youngest in-flight value for one
// source register and raises that operand's interlock term.
module rv_fwd_mux
    import rv_fwd_bypass_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int RA_W          = 5,
    parameter int WB_DEPTH      = 2,
    parameter int ALU2_ISOLATED = 0
) (
    input  logic [RA_W-1:0]                rs,
    input  logic                           rs_used,
    input  logic [XLEN-1:0]                reg_data,
    input  logic [RA_W-1:0]                alu2_rd,
    input  logic                           alu2_reg_write,
    input  logic                           alu2_data_valid,
    input  logic [XLEN-1:0]                alu2_data,
    input  logic [RA_W-1:0]                write_rd,
    input  logic                           write_reg_write,
    input  logic [XLEN-1:0]                wr_data,
    input  logic [WB_DEPTH-1:0]            hist_valid,
    input  logic [WB_DEPTH-1:0][RA_W-1:0]  hist_rd,
    input  logic [WB_DEPTH-1:0][XLEN-1:0]  hist_data,
    output logic [XLEN-1:0]                data,
    output fwd_src_t                       fwd_src,
    output logic                           stall
);

    localparam bit ISOLATED = (ALU2_ISOLATED != 0);

    logic                rs_nonzero;
    logic                alu2_match;
    logic                write_match;
    logic [WB_DEPTH-1:0] hist_match;

    assign rs_nonzero  = (rs != '0);
    assign alu2_match  = alu2_reg_write  && (alu2_rd  == rs) && rs_nonzero;
    assign write_match = write_reg_write && (write_rd == rs) && rs_nonzero;

    always_comb begin
        hist_match = '0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            hist_match[i] = hist_valid[i] && (hist_rd[i] == rs) && rs_nonzero;
        end
    end

    // Lowest priority is applied first so each younger source overrides it.
    always_comb begin
        // NOTE: every output gets a default before any condition, so no path
        // leaves it unassigned and no latch is inferred.
        data    = reg_data;
        fwd_src = SRC_REGFILE;
        for (int i = WB_DEPTH - 1; i >= 0; i--) begin
            if (hist_match[i]) begin
                data    = hist_data[i];
                fwd_src = hist_src(i);
            end
        end
        if (write_match) begin
            data    = wr_data;
            fwd_src = SRC_WRITE;
        end
        if (alu2_match && !ISOLATED) begin
            data    = alu2_data;
            fwd_src = SRC_ALU2;
        end
    end

    // With ALU2 isolated any ALU2 hit must wait for the value to move on.
    assign stall = rs_used && alu2_match && (ISOLATED || !alu2_data_valid);

endmodule

// File: rtl/rv_fwd_bypass.sv
// Operand bypass and load-use interlock: write-back history, one select per
// source operand, and a saturating stall-cycle counter.
module rv_fwd_bypass
    import rv_fwd_bypass_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int RA_W          = 5,
    parameter int NUM_RS        = 2,
    parameter int WB_DEPTH      = 2,
    parameter int ALU2_ISOLATED = 0
) (
    input  logic                        i_clk,
    input  logic                        i_reset_n,
    input  logic                        i_hold,
    input  logic [NUM_RS*RA_W-1:0]      i_rs,
    input  logic [NUM_RS-1:0]           i_rs_used,
    input  logic [NUM_RS*XLEN-1:0]      i_reg_data,
    input  logic [RA_W-1:0]             i_alu2_rd,
    input  logic                        i_alu2_reg_write,
    input  logic                        i_alu2_data_valid,
    input  logic [XLEN-1:0]             i_alu2_data,
    input  logic [RA_W-1:0]             i_write_rd,
    input  logic                        i_write_reg_write,
    input  logic [XLEN-1:0]             i_wr_data,
    input  logic                        i_stall_cnt_clr,
    output logic [NUM_RS*XLEN-1:0]      o_data,
    output logic [NUM_RS*FWD_SRC_W-1:0] o_fwd_src,
    output logic                        o_stall,
    output logic [STALL_CNT_W-1:0]      o_stall_cycles
);

    logic [WB_DEPTH-1:0]           hist_valid_q, hist_valid_d;
    logic [WB_DEPTH-1:0][RA_W-1:0] hist_rd_q,    hist_rd_d;
    logic [WB_DEPTH-1:0][XLEN-1:0] hist_data_q,  hist_data_d;
    logic [STALL_CNT_W-1:0]        stall_cnt_q,  stall_cnt_d;
    logic [NUM_RS-1:0]             stall_vec;

    // Slot 0 is the newest committed write; a hold freezes the whole chain.
    always_comb begin
        hist_valid_d = hist_valid_q;
        hist_rd_d    = hist_rd_q;
        hist_data_d  = hist_data_q;
        if (!i_hold) begin
            hist_valid_d[0] = i_write_reg_write;
            hist_rd_d[0]    = i_write_rd;
            hist_data_d[0]  = i_wr_data;
            for (int i = 1; i < WB_DEPTH; i++) begin
                hist_valid_d[i] = hist_valid_q[i-1];
                hist_rd_d[i]    = hist_rd_q[i-1];
                hist_data_d[i]  = hist_data_q[i-1];
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (i_stall_cnt_clr) begin
            stall_cnt_d = '0;
        end else if (o_stall && (stall_cnt_q != STALL_CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            // NOTE: the history is a register array that is reset in full, not
            // just its valid bits, so nothing stale can forward after release.
            hist_valid_q <= '0;
            hist_rd_q    <= '0;
            hist_data_q  <= '0;
            stall_cnt_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments keep the slot-to-slot shift
            // order-independent: every slot samples the pre-edge values.
            hist_valid_q <= hist_valid_d;
            hist_rd_q    <= hist_rd_d;
            hist_data_q  <= hist_data_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    for (genvar k = 0; k < NUM_RS; k++) begin : g_op
        fwd_src_t fwd_src_k;

        rv_fwd_mux #(
            .XLEN          (XLEN),
            .RA_W          (RA_W),
            .WB_DEPTH      (WB_DEPTH),
            .ALU2_ISOLATED (ALU2_ISOLATED)
        ) u_mux (
            .rs              (i_rs[k*RA_W +: RA_W]),
            .rs_used         (i_rs_used[k]),
            .reg_data        (i_reg_data[k*XLEN +: XLEN]),
            .alu2_rd         (i_alu2_rd),
            .alu2_reg_write  (i_alu2_reg_write),
            .alu2_data_valid (i_alu2_data_valid),
            .alu2_data       (i_alu2_data),
            .write_rd        (i_write_rd),
            .write_reg_write (i_write_reg_write),
            .wr_data         (i_wr_data),
            .hist_valid      (hist_valid_q),
            .hist_rd         (hist_rd_q),
            .hist_data       (hist_data_q),
            .data            (o_data[k*XLEN +: XLEN]),
            .fwd_src         (fwd_src_k),
            .stall           (stall_vec[k])
        );

        assign o_fwd_src[k*FWD_SRC_W +: FWD_SRC_W] = fwd_src_k;
    end

    assign o_stall        = |stall_vec;
    assign o_stall_cycles = stall_cnt_q;

endmodule
